// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encodings and UART frame constants for wb_uart_tx
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  // Transmitter FSM state encodings
  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_LOAD   = 3'd1;
  localparam uart_state_t ST_START  = 3'd2;
  localparam uart_state_t ST_DATA   = 3'd3;
  localparam uart_state_t ST_PARITY = 3'd4;
  localparam uart_state_t ST_STOP   = 3'd5;

  // Frame constants
  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Even parity: XOR of all data bits
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/wb_uart_tx_if.sv
// rtl/wb_uart_tx_if.sv - write-only Wishbone byte port of the UART transmitter
interface wb_uart_tx_if;
  import uart_pkg::*;

  logic                      i_wb_cyc;
  logic                      i_wb_stb;
  logic [UART_DATA_BITS-1:0] i_wb_data;
  logic                      o_wb_ack;
  logic                      o_wb_stall;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_data,
    input  o_wb_ack, o_wb_stall
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_data,
    output o_wb_ack, o_wb_stall
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO with registered full/empty flags
module uart_tx_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);
  localparam int              DEPTH    = 1 << AW;
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_r;
  logic          full_r;
  logic          empty_r;
  logic          do_push;
  logic          do_pop;

  // Refuse a push while full and a pop while empty so pointers never cross
  assign do_push  = push && !full_r;
  assign do_pop   = pop && !empty_r;
  assign pop_data = mem[rd_ptr];
  assign full     = full_r;
  assign empty    = empty_r;

  // Storage array; no reset needed because pointers gate every read
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and flags; a simultaneous push and pop leaves occupancy unchanged
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (do_push && !do_pop) begin
        count_r <= count_r + CNT_ONE;
        full_r  <= (count_r == CNT_FULL - CNT_ONE);
        empty_r <= 1'b0;
      end else if (do_pop && !do_push) begin
        count_r <= count_r - CNT_ONE;
        full_r  <= 1'b0;
        empty_r <= (count_r == CNT_ONE);
      end
    end
  end

endmodule

// File: rtl/wb_uart_tx.sv
// rtl/wb_uart_tx.sv - Wishbone-fed UART transmitter, 8N1 (8E1 when UART_TX_PARITY_EN is defined)
module wb_uart_tx #(
  parameter int BAUD_DIV_RATE  = 2604,
  parameter int BAUD_DIV_WIDTH = 12,
  parameter int FIFO_AW        = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  wb_uart_tx_if.slave wb,
  output logic        uart_tx,
  output logic        uart_busy
);
  import uart_pkg::*;

  localparam logic [BAUD_DIV_WIDTH-1:0] BAUD_RELOAD = BAUD_DIV_WIDTH'(BAUD_DIV_RATE - 1);
  localparam logic [BAUD_DIV_WIDTH-1:0] BAUD_ONE    = BAUD_DIV_WIDTH'(1);
  localparam logic [2:0]                LAST_BIT    = 3'(UART_DATA_BITS - 1);

  uart_state_t               state;
  logic [BAUD_DIV_WIDTH-1:0] baud_cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic                      tx_r;
  logic                      ack_r;
  logic                      accept;
  logic                      baud_done;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_rd_data;
`ifdef UART_TX_PARITY_EN
  logic                      parity_bit;
`endif

  assign accept        = wb.i_wb_cyc && wb.i_wb_stb && !fifo_full;
  assign wb.o_wb_stall = fifo_full;
  assign wb.o_wb_ack   = ack_r;
  assign baud_done     = (baud_cnt == '0);
  assign uart_tx       = tx_r;
  assign uart_busy     = (state != ST_IDLE) || !fifo_empty;

  // The FSM only enters LOAD with data queued, so LOAD doubles as the pop strobe
  uart_tx_fifo #(
    .AW (FIFO_AW),
    .DW (UART_DATA_BITS)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .push      (accept),
    .push_data (wb.i_wb_data),
    .pop       (state == ST_LOAD),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Acknowledge each accepted write one cycle later
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ack_r <= 1'b0;
    end else begin
      ack_r <= accept;
    end
  end

  // Frame sequencer: every bit period starts with a reload and ends when the counter hits zero
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      tx_r      <= UART_IDLE_LEVEL;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          tx_r <= UART_IDLE_LEVEL;
          if (!fifo_empty) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          shift_reg <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
          parity_bit <= even_parity(fifo_rd_data);
`endif
          tx_r     <= ~UART_IDLE_LEVEL;
          baud_cnt <= BAUD_RELOAD;
          state    <= ST_START;
        end
        ST_START: begin
          if (baud_done) begin
            tx_r      <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[UART_DATA_BITS-1:1]};
            bit_idx   <= '0;
            baud_cnt  <= BAUD_RELOAD;
            state     <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx_r  <= parity_bit;
              state <= ST_PARITY;
`else
              tx_r  <= UART_IDLE_LEVEL;
              state <= ST_STOP;
`endif
            end else begin
              tx_r      <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[UART_DATA_BITS-1:1]};
              bit_idx   <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end
        end
        ST_PARITY: begin
          if (baud_done) begin
            tx_r     <= UART_IDLE_LEVEL;
            baud_cnt <= BAUD_RELOAD;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end
        end
        ST_STOP: begin
          tx_r <= UART_IDLE_LEVEL;
          if (baud_done) begin
            state <= fifo_empty ? ST_IDLE : ST_LOAD;
          end else begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end
        end
        default: begin
          tx_r  <= UART_IDLE_LEVEL;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_uart_tx.sv
// tb/tb_wb_uart_tx.sv - directed self-checking bench for wb_uart_tx (BAUD_DIV_RATE=4)
module tb_wb_uart_tx;
  import uart_pkg::*;

  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FCYC = NB * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_tx;
  logic uart_busy;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic [7:0] rx_data_q [$];
  bit         rx_ok_q   [$];
  int         rx_t_q    [$];
  bit         rx_par_q  [$];

  wb_uart_tx_if bus ();

  wb_uart_tx #(
    .BAUD_DIV_RATE  (DIV),
    .BAUD_DIV_WIDTH (12),
    .FIFO_AW        (4)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .wb        (bus),
    .uart_tx   (uart_tx),
    .uart_busy (uart_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line monitor: captures each frame cycle by cycle from the start-bit fall
  initial begin : line_mon
    bit          active;
    int          n;
    int          t0;
    logic [FCYC-1:0] s;
    logic [7:0]  d;
    bit          ok;
    bit          par;
    active = 0; n = 0; t0 = 0; s = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
      end else if (!active) begin
        if (uart_tx === 1'b0) begin
          active = 1; s[0] = 1'b0; n = 1; t0 = cyc;
        end
      end else begin
        s[n] = uart_tx;
        n++;
        if (n == FCYC) begin
          ok = 1;
          for (int b = 0; b < NB; b++)
            for (int c = 0; c < DIV; c++)
              if (s[b*DIV+c] !== s[b*DIV]) ok = 0;
          if (s[0] !== 1'b0) ok = 0;
          if (s[(NB-1)*DIV] !== 1'b1) ok = 0;
          for (int i = 0; i < 8; i++) d[i] = s[(i+1)*DIV];
`ifdef UART_TX_PARITY_EN
          par = s[9*DIV];
`else
          par = 0;
`endif
          rx_data_q.push_back(d);
          rx_ok_q.push_back(ok);
          rx_t_q.push_back(t0);
          rx_par_q.push_back(par);
          active = 0;
        end
      end
    end
  end

  task automatic wb_write(input logic [7:0] d, input string tag);
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_data = d;
    @(negedge clk);
    check(tag, int'(bus.o_wb_ack), 1);
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
  endtask

  task automatic wait_rx(input int n, input string tag);
    int b = 0;
    while (rx_data_q.size() < n && b < 3000) begin
      @(negedge clk);
      b++;
    end
    check(tag, int'(rx_data_q.size() >= n), 1);
  endtask

  task automatic wait_state(input logic [2:0] st, input int idx, input int occ, input string tag);
    int  b = 0;
    bit  hit = 0;
    while (!hit && b < 3000) begin
      @(negedge clk);
      b++;
      if (dut.state == st && (idx < 0 || int'(dut.bit_idx) == idx) &&
          (occ < 0 || int'(dut.u_fifo.count_r) == occ))
        hit = 1;
    end
    check(tag, int'(hit), 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int         t_acc;
    int         acks;
    int         last_ack;
    bit         all_ok;
    bit         low_seen;
    logic [7:0] exp_b;
    logic [7:0] v4 [4];
    v4[0] = 8'hFF; v4[1] = 8'h11; v4[2] = 8'h22; v4[3] = 8'h33;

    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_data = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", int'(uart_tx), 1);
    check("rst_ack", int'(bus.o_wb_ack), 0);
    check("rst_stall", int'(bus.o_wb_stall), 0);
    check("rst_busy", int'(uart_busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte 0x55: ack timing, 2-cycle fall latency, exact bit timing
    wb_write(8'h55, "t1_ack");
    t_acc = cyc;
    check("t1_busy", int'(uart_busy), 1);
    @(negedge clk);
    check("t1_ack_once", int'(bus.o_wb_ack), 0);
    check("t1_load_high", int'(uart_tx), 1);
    wait_rx(1, "t1_rx_timeout");
    check("t1_data", int'(rx_data_q[0]), 'h55);
    check("t1_frame_ok", int'(rx_ok_q[0]), 1);
    check("t1_latency", rx_t_q[0] - t_acc, 2);
    @(negedge clk);
    check("t1_idle_busy", int'(uart_busy), 0);
    rx_data_q.delete(); rx_ok_q.delete(); rx_t_q.delete(); rx_par_q.delete();

    // Back-to-back 0xA3, 0x3A: one LOAD cycle between frames
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_data = 8'hA3;
    @(negedge clk);
    check("t2_ack0", int'(bus.o_wb_ack), 1);
    bus.i_wb_data = 8'h3A;
    @(negedge clk);
    check("t2_ack1", int'(bus.o_wb_ack), 1);
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    wait_rx(2, "t2_rx_timeout");
    check("t2_data0", int'(rx_data_q[0]), 'hA3);
    check("t2_data1", int'(rx_data_q[1]), 'h3A);
    check("t2_ok", int'(rx_ok_q[0] && rx_ok_q[1]), 1);
    check("t2_spacing", rx_t_q[1] - rx_t_q[0], FCYC + 1);
    @(negedge clk);
    rx_data_q.delete(); rx_ok_q.delete(); rx_t_q.delete(); rx_par_q.delete();

    // Fill while a frame is in flight: 17 strobes -> 16 acks, stall on the 17th
    wb_write(8'hEE, "t3_ack_ee");
    acks = 0; last_ack = 0;
    for (int i = 0; i < 17; i++) begin
      bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_data = 8'(i);
      if (i == 16) check("t3_stall_17th", int'(bus.o_wb_stall), 1);
      @(negedge clk);
      last_ack = int'(bus.o_wb_ack);
      acks += last_ack;
    end
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    check("t3_ack_count", acks, 16);
    check("t3_no_ack_17th", last_ack, 0);

    // Push and pop in the same cycle at occupancy 16: push refused, occupancy drops to 15
    wait_state(ST_LOAD, -1, -1, "t3_load16_timeout");
    check("t3_occ16", int'(dut.u_fifo.count_r), 16);
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_data = 8'h99;
    @(negedge clk);
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    check("t3_full_noack", int'(bus.o_wb_ack), 0);
    check("t3_occ15", int'(dut.u_fifo.count_r), 15);
    check("t3_stall_clear", int'(bus.o_wb_stall), 0);

    // Push and pop in the same cycle at occupancy 5: occupancy stays 5
    wait_state(ST_LOAD, -1, 5, "t3_load5_timeout");
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_data = 8'h77;
    @(negedge clk);
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    check("t3_occ5_ack", int'(bus.o_wb_ack), 1);
    check("t3_occ5", int'(dut.u_fifo.count_r), 5);

    wait_rx(18, "t3_rx_timeout");
    all_ok = 1;
    for (int k = 0; k < 18; k++) begin
      if (k == 0) exp_b = 8'hEE;
      else if (k <= 16) exp_b = 8'(k - 1);
      else exp_b = 8'h77;
      check($sformatf("t3_order_%0d", k), int'(rx_data_q[k]), int'(exp_b));
      if (!rx_ok_q[k]) all_ok = 0;
    end
    check("t3_frames_ok", int'(all_ok), 1);
    @(negedge clk);
    check("t3_frame_count", rx_data_q.size(), 18);
    check("t3_idle_busy", int'(uart_busy), 0);
    rx_data_q.delete(); rx_ok_q.delete(); rx_t_q.delete(); rx_par_q.delete();

    // Reset during data bit 3 of 0xFF with 3 bytes queued
    for (int i = 0; i < 4; i++) begin
      bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_data = v4[i];
      @(negedge clk);
    end
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    wait_state(ST_DATA, 3, -1, "t4_bit3_timeout");
    check("t4_queued", int'(dut.u_fifo.count_r), 3);
    rst = 1'b1;
    @(negedge clk);
    check("t4_tx_high", int'(uart_tx), 1);
    check("t4_busy", int'(uart_busy), 0);
    check("t4_stall", int'(bus.o_wb_stall), 0);
    check("t4_ack", int'(bus.o_wb_ack), 0);
    @(negedge clk);
    rst = 1'b0;
    low_seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || uart_busy !== 1'b0) low_seen = 1;
    end
    check("t4_no_frames", int'(low_seen), 0);
    check("t4_rx_empty", rx_data_q.size(), 0);

`ifdef UART_TX_PARITY_EN
    // Even parity bit: 0x07 has three ones, 0x03 has two
    wb_write(8'h07, "t5_ack07");
    wait_rx(1, "t5_rx07_timeout");
    check("t5_data07", int'(rx_data_q[0]), 'h07);
    check("t5_par07", int'(rx_par_q[0]), 1);
    check("t5_ok07", int'(rx_ok_q[0]), 1);
    @(negedge clk);
    wb_write(8'h03, "t5_ack03");
    wait_rx(2, "t5_rx03_timeout");
    check("t5_data03", int'(rx_data_q[1]), 'h03);
    check("t5_par03", int'(rx_par_q[1]), 0);
    check("t5_ok03", int'(rx_ok_q[1]), 1);
`endif

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_uart_tx.md
WB_UART_TX -- requirements
Module: wb_uart_tx

Interface
REQ-001 SHALL have parameter BAUD_DIV_RATE, default 2604, meaning i_clk cycles per UART bit (minimum 2).
REQ-002 SHALL have parameter BAUD_DIV_WIDTH, default 12, meaning width of the baud counter.
REQ-003 SHALL have parameter FIFO_AW, default 4, meaning log2 of FIFO depth (16 entries).
REQ-004 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_wb_cyc  input  1  Wishbone cycle.
REQ-007 SHALL have port i_wb_stb  input  1  Wishbone strobe, a write request.
REQ-008 SHALL have port i_wb_data  input  8  byte to transmit.
REQ-009 SHALL have port o_wb_ack  output  1  write acknowledge.
REQ-010 SHALL have port o_wb_stall  output  1  FIFO full, write refused.
REQ-011 SHALL have port uart_tx  output  1  serial line, idle high, registered.
REQ-012 SHALL have port uart_busy  output  1  high while a frame is on the line or the FIFO is non-empty.

Function
REQ-013 SHALL accept a write on an edge where i_wb_cyc && i_wb_stb && !o_wb_stall, storing i_wb_data into the FIFO.
REQ-014 SHALL pulse o_wb_ack for exactly one cycle, on the cycle after acceptance; no ack for a stalled strobe.
REQ-015 SHALL drive o_wb_stall combinationally equal to the registered FIFO-full flag (occupancy == 2^FIFO_AW).
REQ-016 SHALL, with a simultaneous accepted push and FSM pop, leave occupancy unchanged and preserve FIFO order.
REQ-017 SHALL wrap read and write pointers modulo 2^FIFO_AW, with occupancy tracked in FIFO_AW+1 bits.
REQ-018 SHALL implement FSM states IDLE, LOAD, START, DATA, PARITY, STOP.
REQ-019 SHALL transition IDLE->LOAD when FIFO non-empty, and LOAD SHALL pop one byte into the shift register while the line is held high for 1 cycle.
REQ-020 SHALL make LOAD->START unconditional, with uart_tx=0 for BAUD_DIV_RATE cycles.
REQ-021 SHALL, in DATA, send 8 bits LSB first, each held BAUD_DIV_RATE cycles, counted by a 3-bit bit index.
REQ-022 SHALL send STOP with uart_tx=1 for BAUD_DIV_RATE cycles, then go to LOAD if FIFO non-empty, else IDLE.
REQ-023 SHALL make uart_tx fall 2 cycles after the FIFO becomes non-empty from IDLE; back-to-back frames SHALL be separated by exactly 1 extra high cycle (the LOAD cycle).
REQ-024 SHALL reload the baud counter to BAUD_DIV_RATE-1 on entry to every bit, and advance the bit on the counter reaching 0.
REQ-025 SHALL never alter an in-flight frame due to bus writes, including writes while full.

Reset
REQ-026 SHALL, on i_reset, set state=IDLE, uart_tx=1, o_wb_ack=0, FIFO empty (o_wb_stall=0), uart_busy=0, counters 0.
REQ-027 SHALL, on reset asserted mid-frame, abort the frame and discard FIFO contents; uart_tx SHALL be high the cycle after the reset edge.

Configuration
REQ-028 SHALL use macro UART_TX_PARITY_EN: when defined, DATA->PARITY sends even parity (XOR of 8 data bits) for BAUD_DIV_RATE cycles before STOP.
REQ-029 SHALL, without UART_TX_PARITY_EN, go DATA->STOP directly, and SHALL NOT reach PARITY (frame = 10 bits).

Structure
REQ-030 SHALL place FSM state encodings (3-bit localparam set) and UART frame constants (data bits=8, idle level) in shared package uart_pkg.
REQ-031 SHALL implement the FIFO as sub-module uart_tx_fifo (synchronous, registered full/empty, push/pop strobes); the baud counter and FSM stay in the top module.

Verification
REQ-032 SHALL cover: BAUD_DIV_RATE=4, write 0x55 -> uart_tx 0,1,0,1,0,1,0,1,0,1, each for 4 cycles, o_wb_ack one cycle after the strobe.
REQ-033 SHALL cover: 17 consecutive strobes with the line stalled from the first pop blocked -> 16 acks, stall high on the 17th; bytes 0x00..0x0F emitted in order.
REQ-034 SHALL cover: writes 0xA3 then 0x3A back-to-back -> the second start bit begins exactly 5 cycles (4 stop + 1 LOAD) after the first stop bit begins.
REQ-035 SHALL cover: reset in DATA bit 3 of 0xFF with 3 bytes queued -> uart_tx=1 next cycle, uart_busy=0, no further frames.
REQ-036 SHALL cover: UART_TX_PARITY_EN defined, write 0x07 -> parity bit 1; write 0x03 -> parity bit 0; 11-bit frames.
REQ-037 SHALL cover: push and pop on the same cycle at occupancy 16 -> push stalled, occupancy 15 next cycle; at occupancy 5 -> stays 5.
